// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stage boundaries: machine width, reset PC,
// and the payload structures carried by pipe_stage_buf between stages.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;

    // IF -> ID payload: fetched pc, instruction word, sequential next pc.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] snpc;
    } fd_payload_t;

    localparam int FD_W = $bits(fd_payload_t);

    // ID -> EX payload: decoded operands and destination.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] snpc;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
    } de_payload_t;

    localparam int DE_W = $bits(de_payload_t);

    // EX -> MEM payload: ALU result, store data and writeback control.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu_res;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
        logic            wb_en;
    } em_payload_t;

    localparam int EM_W = $bits(em_payload_t);

    // Builds an IF->ID payload with the sequential next pc filled in.
    function automatic fd_payload_t make_fd(input logic [XLEN-1:0] pc,
                                            input logic [XLEN-1:0] inst);
        fd_payload_t p;
        p.pc   = pc;
        p.inst = inst;
        p.snpc = pc + 32'd4;
        return p;
    endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
// Elastic buffer between two pipeline stages with valid/ready on both sides and
// a synchronous flush for redirects. DEPTH=0 is a combinational pass-through;
// DEPTH>=1 is a circular buffer of DEPTH registered entries (one transfer per
// cycle for DEPTH>=2, no same-cycle bypass).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             drop all buffered entries and any same-cycle push
//   s_valid/s_ready   upstream handshake, s_data payload
//   m_valid/m_ready   downstream handshake, m_data head payload
//   count             number of occupied entries (always 0 in pass-through)
// -----------------------------------------------------------------------------
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int               DATA_W     = FD_W,
    parameter int               DEPTH      = 2,
    parameter logic [DATA_W-1:0] RESET_DATA = DATA_W'({RESET_PC, 64'h0}),
    localparam int              CNT_W      = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  count
);

    if (DEPTH == 0) begin : g_pass

        // Flush kills the transfer combinationally: downstream sees nothing and
        // upstream is told the beat was consumed.
        assign m_valid = s_valid & ~flush;
        assign s_ready = m_ready | flush;
        assign m_data  = s_data;
        assign count   = '0;

        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;

    end else begin : g_reg

        localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
        localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
        localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

        logic [DATA_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]  rd_ptr;
        logic [PTR_W-1:0]  wr_ptr;
        logic [CNT_W-1:0]  occ;
        logic              push;
        logic              pop;

        // Explicit wrap so non-power-of-2 depths never index past the last slot.
        function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
            return (p == LAST) ? '0 : p + 1'b1;
        endfunction

        // Flags come only from registered occupancy, so m_ready has no
        // combinational path to s_ready; a full buffer frees its slot next cycle.
        assign s_ready = (occ != FULL);
        assign m_valid = (occ != '0);
        assign m_data  = mem[rd_ptr];
        assign count   = occ;

        assign push = s_valid & s_ready;
        assign pop  = m_valid & m_ready;

        // A flushed push is not written, which leaves stale entries in place;
        // they are unreachable because occupancy is cleared.
        always_ff @(posedge clk) begin
            if (rst) begin
                occ    <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= RESET_DATA;
                end
            end else begin
                if (push && !flush) begin
                    mem[wr_ptr] <= s_data;
                end
                if (flush) begin
                    occ    <= '0;
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                end else begin
                    if (push) begin
                        wr_ptr <= ptr_inc(wr_ptr);
                    end
                    if (pop) begin
                        rd_ptr <= ptr_inc(rd_ptr);
                    end
                    if (push && !pop) begin
                        occ <= occ + 1'b1;
                    end else if (pop && !push) begin
                        occ <= occ - 1'b1;
                    end
                end
            end
        end

    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline buffer with a valid/ready handshake on both sides.
- Carries an opaque payload (for IF->ID: {pc, inst, snpc}) between any two pipeline stages.
- Sustains one transfer per cycle with DEPTH entries of elastic storage, and adds a synchronous flush for branch/trap redirect.
- DEPTH=0 selects single-cycle pass-through mode.

Parameters:
- DATA_W, 96: payload width in bits.
- DEPTH, 2: number of storage entries. 0 selects combinational pass-through; 1 or more selects registered mode. Non-power-of-2 values are legal.
- RESET_DATA, {32'h80000000, 64'h0}: value loaded into every entry at reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high, sampled on posedge clk.
- flush  in  1  discard all buffered entries and any same-cycle input.
- s_valid  in  1  upstream payload valid.
- s_ready  out  1  buffer can accept.
- s_data  in  DATA_W  upstream payload.
- m_valid  out  1  head entry valid.
- m_ready  in  1  downstream accepts.
- m_data  out  DATA_W  head entry payload.
- count  out  $clog2(DEPTH+1) (1 if DEPTH=0)  occupied entries.

Behaviour:
- Transfers:
  - push = s_valid & s_ready.
  - pop = m_valid & m_ready.
- Registered mode (DEPTH>=1), circular storage:
  - Storage is mem[DEPTH], with rd_ptr and wr_ptr each wrapping from DEPTH-1 to 0.
- Reset:
  - count=0, rd_ptr=wr_ptr=0, all mem entries = RESET_DATA.
  - Resulting outputs: s_ready=1, m_valid=0, m_data=RESET_DATA.
  - rst overrides flush and any handshake in the same cycle.
- Output flags:
  - s_ready = (count != DEPTH). It is a function of registered state only; there is no combinational path from m_ready to s_ready.
  - m_valid = (count != 0).
  - m_data = mem[rd_ptr]. It is stable while m_valid & !m_ready, and don't-care when m_valid=0.
- Latency:
  - A push into an empty buffer appears on m_valid/m_data on the next cycle.
  - There is no same-cycle bypass.
- Occupancy updates:
  - push & !pop: count+1, wr_ptr advances.
  - pop & !push: count-1, rd_ptr advances.
  - push & pop: count unchanged, both pointers advance. This gives full throughput at DEPTH>=2.
- Full (count==DEPTH):
  - s_ready=0 even when m_ready=1. The slot frees on the next cycle.
  - At DEPTH=1 this gives at most one transfer per two cycles, matching the legacy IDLE/WAIT_READY behaviour.
- Empty (count==0): m_valid=0, and m_ready is ignored.
- Flush:
  - On the next edge: count=0 and rd_ptr=wr_ptr=0.
  - Any same-cycle push is discarded, even though s_ready may be high (upstream considers it consumed).
  - A same-cycle pop completes normally downstream.
  - mem contents are not cleared.
  - m_valid=0 on the cycle after flush.
- Pass-through mode (DEPTH=0):
  - m_valid=s_valid, s_ready=m_ready, m_data=s_data, count=0.
  - flush gates the transfer combinationally: m_valid = s_valid & !flush, s_ready = m_ready | flush.
- Protocol obligations:
  - Once m_valid is asserted, it and m_data hold until pop or flush.
  - Upstream may drop s_valid at any time. The buffer must not rely on upstream stability.

Decomposition:
- Package pipe_pkg holds:
  - XLEN=32 and RESET_PC=32'h80000000.
  - Struct fd_payload_t {pc, inst, snpc} and its width FD_W=96.
  - Payload structs for later stage boundaries (de_payload_t, ...).
- No sub-module. Pointer wrap logic is a local function; the DEPTH=0 and DEPTH>=1 variants are generate branches.

Test Plan:
- Reset, DEPTH=2: assert rst 2 cycles -> s_ready=1, m_valid=0, count=0, m_data=96'h80000000_00000000_00000000.
- Streaming, DEPTH=2, m_ready=1 constant, push A..H on 8 consecutive cycles -> 8 pops on 8 consecutive cycles, each one cycle after its push, in order; count never exceeds 1.
- Backpressure, DEPTH=2, m_ready=0, push A,B,C -> A and B accepted, count=2, s_ready=0, C held. Raise m_ready -> A pops, s_ready=1 next cycle, C accepted, final order A,B,C.
- DEPTH=3 wrap: 10 pushes with m_ready toggling 1,0,1,0... -> output order equals input order; count stays within 0..3; pointers wrap 2->0 with no loss or duplicate.
- Flush, DEPTH=2: count=2 and flush=1 with s_valid=1 (payload X), m_ready=1 -> head pops that cycle; next cycle count=0, m_valid=0, and X never appears.
- DEPTH=0: drive s_valid=1, s_data=D, m_ready=0 -> m_valid=1, m_data=D, s_ready=0 same cycle. Then flush=1 -> m_valid=0, s_ready=1 same cycle.
